// File: rtl/sampler_ctrl_pkg.sv
// Shared constants, state encoding and control-word helper for the sampler capture sequencer.
package sampler_ctrl_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  // Sampler register map
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD = 6'h04;
  localparam logic [ADDR_W-1:0] ADDR_RISE   = 6'h08;
  localparam logic [ADDR_W-1:0] ADDR_FALL   = 6'h0C;

  // Control register fields
  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_CLR_BIT   = 1;
  localparam int unsigned CTRL_LOGCH_LSB = 8;
  localparam int unsigned CTRL_LOGCH_W   = 3;

  // Status register fields (read back from ADDR_CTRL)
  localparam int unsigned STAT_BUSY_BIT = 5;
  localparam int unsigned STAT_OVF_LSB  = 6;
  localparam int unsigned STAT_OVF_W    = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_ARM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_STOP  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Assemble a control-register write value
  function automatic logic [DATA_W-1:0] ctrl_word(input logic en, input logic clr,
                                                  input logic [CTRL_LOGCH_W-1:0] log_ch);
    logic [DATA_W-1:0] w;
    w = '0;
    w[CTRL_EN_BIT] = en;
    w[CTRL_CLR_BIT] = clr;
    w[CTRL_LOGCH_LSB +: CTRL_LOGCH_W] = log_ch;
    return w;
  endfunction

endpackage

// File: rtl/sampler_trigger_match.sv
// Registered masked pattern comparator; hit follows the sample bus by one cycle.
module sampler_trigger_match
  import sampler_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] mask,
  input  logic [DATA_W-1:0] value,
  output logic              hit
);

  // Register the masked equality so the FSM sees a clean, timed compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit <= 1'b0;
    end else begin
      hit <= ((sample & mask) == (value & mask));
    end
  end

endmodule

// File: rtl/sampler_capture_ctrl.sv
// Capture sequencer: programs the sampler, waits for the trigger, counts words, stops and drains.
module sampler_capture_ctrl
  import sampler_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DATA_W-1:0]       cfg_period,
  input  logic [DATA_W-1:0]       cfg_rise_mask,
  input  logic [DATA_W-1:0]       cfg_fall_mask,
  input  logic [CTRL_LOGCH_W-1:0] cfg_log_channels,
  input  logic [DATA_W-1:0]       cfg_trig_mask,
  input  logic [DATA_W-1:0]       cfg_trig_value,
  input  logic [CNT_W-1:0]        cfg_word_count,
  input  logic [DATA_W-1:0]       trig_s,
  input  logic                    smp_out_valid,
  output logic                    avalid,
  output logic                    awe,
  output logic [ADDR_W-1:0]       aaddr,
  output logic [DATA_W-1:0]       adata,
  input  logic                    bvalid,
  input  logic [DATA_W-1:0]       bdata,
  output logic                    busy,
  output logic                    armed,
  output logic                    done,
  output logic                    aborted,
  output logic                    overflow_seen,
  output logic [CNT_W-1:0]        words_captured,
  output logic [2:0]              state_o
);

  state_t           state;
  logic [1:0]       step;
  logic             hit;
  logic [CNT_W-1:0] cnt_inc;
  logic             term_hit;
  logic             rd_resp;
  logic             unused_bdata;

  sampler_trigger_match u_trig (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (trig_s),
    .mask   (cfg_trig_mask),
    .value  (cfg_trig_value),
    .hit    (hit)
  );

  // Saturating increment and terminal-count detect on the incremented value
  assign cnt_inc  = (words_captured == '1) ? words_captured : words_captured + CNT_W'(1);
  assign term_hit = smp_out_valid && (cfg_word_count != '0) && (cnt_inc == cfg_word_count);

  // A response is only ours when no new request is on the bus; this drops write acks
  assign rd_resp = bvalid && !avalid;

  assign state_o = state;

  assign unused_bdata = ^{bdata[DATA_W-1:STAT_OVF_LSB+STAT_OVF_W], bdata[STAT_BUSY_BIT-1:0]};

  // Sequencer FSM with registered bus and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      step           <= 2'd0;
      avalid         <= 1'b0;
      awe            <= 1'b0;
      aaddr          <= '0;
      adata          <= '0;
      busy           <= 1'b0;
      armed          <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      overflow_seen  <= 1'b0;
      words_captured <= '0;
    end else begin
      avalid <= 1'b0;
      awe    <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state         <= ST_CFG;
            step          <= 2'd1;
            busy          <= 1'b1;
            aborted       <= 1'b0;
            overflow_seen <= 1'b0;
            avalid        <= 1'b1;
            awe           <= 1'b1;
            aaddr         <= ADDR_CTRL;
            adata         <= ctrl_word(1'b0, 1'b1, 3'd0);
          end
        end
        ST_CFG: begin
          if (abort) begin
            state   <= ST_STOP;
            aborted <= 1'b1;
            avalid  <= 1'b1;
            awe     <= 1'b1;
            aaddr   <= ADDR_CTRL;
            adata   <= '0;
          end else begin
            case (step)
              2'd1: begin
                avalid <= 1'b1;
                awe    <= 1'b1;
                aaddr  <= ADDR_PERIOD;
                adata  <= cfg_period;
                step   <= 2'd2;
              end
              2'd2: begin
                avalid <= 1'b1;
                awe    <= 1'b1;
                aaddr  <= ADDR_RISE;
                adata  <= cfg_rise_mask;
                step   <= 2'd3;
              end
              2'd3: begin
                avalid <= 1'b1;
                awe    <= 1'b1;
                aaddr  <= ADDR_FALL;
                adata  <= cfg_fall_mask;
                step   <= 2'd0;
              end
              default: begin
                state <= ST_ARM;
                armed <= 1'b1;
              end
            endcase
          end
        end
        ST_ARM: begin
          if (abort) begin
            state   <= ST_STOP;
            armed   <= 1'b0;
            aborted <= 1'b1;
            avalid  <= 1'b1;
            awe     <= 1'b1;
            aaddr   <= ADDR_CTRL;
            adata   <= '0;
          end else if (hit) begin
            state          <= ST_RUN;
            armed          <= 1'b0;
            words_captured <= '0;
            avalid         <= 1'b1;
            awe            <= 1'b1;
            aaddr          <= ADDR_CTRL;
            adata          <= ctrl_word(1'b1, 1'b0, cfg_log_channels);
          end
        end
        ST_RUN: begin
          if (smp_out_valid) begin
            words_captured <= cnt_inc;
          end
          if (term_hit || abort) begin
            state   <= ST_STOP;
            aborted <= !term_hit;
            avalid  <= 1'b1;
            awe     <= 1'b1;
            aaddr   <= ADDR_CTRL;
            adata   <= '0;
          end
        end
        ST_STOP: begin
          if (smp_out_valid) begin
            words_captured <= cnt_inc;
          end
          state  <= ST_DRAIN;
          avalid <= 1'b1;
          aaddr  <= ADDR_CTRL;
        end
        ST_DRAIN: begin
          if (smp_out_valid) begin
            words_captured <= cnt_inc;
          end
          if (rd_resp) begin
            if (bdata[STAT_BUSY_BIT]) begin
              avalid <= 1'b1;
              aaddr  <= ADDR_CTRL;
            end else begin
              overflow_seen <= |bdata[STAT_OVF_LSB +: STAT_OVF_W];
              state         <= ST_DONE;
              busy          <= 1'b0;
              done          <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          armed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sampler_capture_ctrl.sv
// Directed self-checking bench for sampler_capture_ctrl with a simple sampler bus responder.
module tb_sampler_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [31:0] cfg_period, cfg_rise_mask, cfg_fall_mask;
  logic [2:0]  cfg_log_channels;
  logic [31:0] cfg_trig_mask, cfg_trig_value;
  logic [31:0] cfg_word_count;
  logic [31:0] trig_s;
  logic        smp_out_valid;
  logic        avalid, awe;
  logic [5:0]  aaddr;
  logic [31:0] adata;
  logic        bvalid;
  logic [31:0] bdata;
  logic        busy, armed, done, aborted, overflow_seen;
  logic [31:0] words_captured;
  logic [2:0]  state_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_reads = 0;
  int n_en    = 0;
  int r0, e0;
  logic [31:0] poll_q[$];

  always #5 clk = ~clk;

  sampler_capture_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_period(cfg_period), .cfg_rise_mask(cfg_rise_mask), .cfg_fall_mask(cfg_fall_mask),
    .cfg_log_channels(cfg_log_channels), .cfg_trig_mask(cfg_trig_mask),
    .cfg_trig_value(cfg_trig_value), .cfg_word_count(cfg_word_count), .trig_s(trig_s),
    .smp_out_valid(smp_out_valid), .avalid(avalid), .awe(awe), .aaddr(aaddr), .adata(adata),
    .bvalid(bvalid), .bdata(bdata), .busy(busy), .armed(armed), .done(done),
    .aborted(aborted), .overflow_seen(overflow_seen), .words_captured(words_captured),
    .state_o(state_o)
  );

  // Sampler bus model: response one cycle after each request, poll data from a queue
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid <= 1'b0;
      bdata  <= 32'h0;
    end else begin
      bvalid <= avalid;
      bdata  <= 32'h0;
      if (avalid && !awe) begin
        n_reads <= n_reads + 1;
        if (poll_q.size() != 0) bdata <= poll_q.pop_front();
      end
      if (avalid && awe && aaddr == 6'h00 && adata[0]) n_en <= n_en + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [5:0] addr, input logic [31:0] data);
    check(tag, 64'({avalid, awe, aaddr, adata}), 64'({1'b1, 1'b1, addr, data}));
  endtask

  task automatic chk_rd(input string tag);
    check(tag, 64'({avalid, awe, aaddr}), 64'({1'b1, 1'b0, 6'h00}));
  endtask

  task automatic chk_nobus(input string tag);
    check(tag, 64'(avalid), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; smp_out_valid = 1'b0; trig_s = 32'h0;
    cfg_period = 32'h100; cfg_rise_mask = 32'h11; cfg_fall_mask = 32'h22;
    cfg_log_channels = 3'd3; cfg_trig_mask = 32'h0; cfg_trig_value = 32'h0;
    cfg_word_count = 32'd4;
    tick(); tick();

    // Reset state
    check("rst_state", 64'(state_o), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_bus", 64'({avalid, awe, aaddr, adata}), 64'(0));
    check("rst_words", 64'(words_captured), 64'(0));
    check("rst_flags", 64'({armed, done, aborted, overflow_seen}), 64'(0));
    rst_n = 1'b1;
    tick();

    // S1: mask 0, target 4
    start = 1'b1; tick(); start = 1'b0;
    chk_wr("s1_wr_ctrl_clr", 6'h00, 32'h2);
    check("s1_state_cfg", 64'(state_o), 64'(1));
    check("s1_busy", 64'(busy), 64'(1));
    tick(); chk_wr("s1_wr_period", 6'h04, 32'h100);
    tick(); chk_wr("s1_wr_rise", 6'h08, 32'h11);
    tick(); chk_wr("s1_wr_fall", 6'h0C, 32'h22);
    tick();
    chk_nobus("s1_arm_bus");
    check("s1_state_arm", 64'(state_o), 64'(2));
    check("s1_armed", 64'(armed), 64'(1));
    tick();
    chk_wr("s1_wr_enable", 6'h00, 32'h301);
    check("s1_state_run", 64'(state_o), 64'(3));
    check("s1_armed_off", 64'(armed), 64'(0));
    smp_out_valid = 1'b1;
    tick(); tick(); tick();
    check("s1_words3", 64'(words_captured), 64'(3));
    check("s1_still_run", 64'(state_o), 64'(3));
    tick(); smp_out_valid = 1'b0;
    chk_wr("s1_wr_disable", 6'h00, 32'h0);
    check("s1_state_stop", 64'(state_o), 64'(4));
    tick();
    chk_rd("s1_poll");
    check("s1_state_drain", 64'(state_o), 64'(5));
    tick();
    chk_nobus("s1_wait_resp");
    check("s1_drain_wait", 64'(state_o), 64'(5));
    tick();
    check("s1_state_done", 64'(state_o), 64'(6));
    check("s1_done_pulse", 64'(done), 64'(1));
    check("s1_words4", 64'(words_captured), 64'(4));
    check("s1_busy_off", 64'(busy), 64'(0));
    check("s1_flags", 64'({aborted, overflow_seen}), 64'(0));
    tick();
    check("s1_done_clear", 64'(done), 64'(0));

    // S2: mask 0xFF value 0xA5, target 1, abort coincides with terminal count
    cfg_trig_mask = 32'hFF; cfg_trig_value = 32'hA5; trig_s = 32'h12;
    cfg_word_count = 32'd1; cfg_log_channels = 3'd5;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    check("s2_arm", 64'(state_o), 64'(2));
    tick();
    check("s2_hold_arm", 64'(state_o), 64'(2));
    chk_nobus("s2_no_enable");
    trig_s = 32'hA5; tick();
    check("s2_arm_one_cycle", 64'(state_o), 64'(2));
    trig_s = 32'h12; tick();
    chk_wr("s2_wr_enable", 6'h00, 32'h501);
    check("s2_run", 64'(state_o), 64'(3));
    smp_out_valid = 1'b1; abort = 1'b1; tick(); abort = 1'b0;
    chk_wr("s2_wr_disable", 6'h00, 32'h0);
    tick();
    chk_rd("s2_poll");
    tick(); smp_out_valid = 1'b0;
    tick();
    check("s2_done", 64'(state_o), 64'(6));
    check("s2_words_post", 64'(words_captured), 64'(3));
    check("s2_not_aborted", 64'(aborted), 64'(0));

    // S3: target 0, abort after 7 words, busy polls then overflow status
    cfg_trig_mask = 32'h0; cfg_word_count = 32'd0; cfg_log_channels = 3'd3;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk_wr("s3_wr_enable", 6'h00, 32'h301);
    smp_out_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    smp_out_valid = 1'b0;
    check("s3_words7", 64'(words_captured), 64'(7));
    check("s3_run", 64'(state_o), 64'(3));
    abort = 1'b1; tick(); abort = 1'b0;
    chk_wr("s3_wr_disable", 6'h00, 32'h0);
    poll_q.push_back(32'h020); poll_q.push_back(32'h020); poll_q.push_back(32'h0C0);
    r0 = n_reads;
    tick(); chk_rd("s3_poll1");
    tick(); chk_nobus("s3_gap1");
    tick(); chk_rd("s3_poll2");
    tick(); tick(); chk_rd("s3_poll3");
    tick(); tick();
    check("s3_done", 64'(state_o), 64'(6));
    check("s3_done_pulse", 64'(done), 64'(1));
    check("s3_overflow", 64'(overflow_seen), 64'(1));
    check("s3_aborted", 64'(aborted), 64'(1));
    check("s3_words", 64'(words_captured), 64'(7));
    check("s3_reads", 64'(n_reads - r0), 64'(3));

    // S4: start while busy ignored, abort in ARM skips the enable write
    cfg_trig_mask = 32'hFF; cfg_trig_value = 32'hA5; trig_s = 32'h0;
    tick();
    e0 = n_en;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk_wr("s4_ignore_start", 6'h08, 32'h11);
    check("s4_cfg", 64'(state_o), 64'(1));
    tick(); tick();
    check("s4_arm", 64'(state_o), 64'(2));
    abort = 1'b1; tick(); abort = 1'b0;
    chk_wr("s4_wr_disable", 6'h00, 32'h0);
    check("s4_stop", 64'(state_o), 64'(4));
    check("s4_armed_off", 64'(armed), 64'(0));
    tick(); tick(); tick();
    check("s4_done", 64'(state_o), 64'(6));
    check("s4_aborted", 64'(aborted), 64'(1));
    check("s4_ovf_cleared", 64'(overflow_seen), 64'(0));
    check("s4_no_enable", 64'(n_en - e0), 64'(0));

    // S5: asynchronous reset during RUN
    cfg_trig_mask = 32'h0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check("s5_run", 64'(state_o), 64'(3));
    smp_out_valid = 1'b1; tick();
    check("s5_words1", 64'(words_captured), 64'(1));
    rst_n = 1'b0; #1;
    check("s5_rst_state", 64'(state_o), 64'(0));
    check("s5_rst_bus", 64'({avalid, awe, aaddr, adata}), 64'(0));
    check("s5_rst_status", 64'({busy, armed, done, aborted, overflow_seen}), 64'(0));
    check("s5_rst_words", 64'(words_captured), 64'(0));
    smp_out_valid = 1'b0;
    tick(); rst_n = 1'b1;
    abort = 1'b1; tick(); abort = 1'b0;
    tick();
    check("s5_abort_idle", 64'({state_o, busy, aborted}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sampler_capture_ctrl.md
# sampler_capture_ctrl

Capture sequencer that drives the sampler's register bus as its sole master. It clears and programs the strober, then waits for a masked trigger pattern on the synchronized input bus. It enables sampling, counts compressed output words up to a target, stops the sampler and polls it until the pipeline drains. It sits between the host-facing config registers and the sampler's `avalid/awe/aaddr/adata/bvalid/bdata` port.

## Interface
- `CNT_W`, 32, width of the word target and the word counter
- `clk`  in  1  single clock, shared with the sampler
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; accepted only in IDLE or DONE
- `abort`  in  1  one-cycle pulse; stops a capture early
- `cfg_period`  in  32  strober timer period
- `cfg_rise_mask`, `cfg_fall_mask`  in  32  strober edge masks
- `cfg_log_channels`  in  3  serializer channel-width code
- `cfg_trig_mask`, `cfg_trig_value`  in  32  trigger pattern; all-zero mask means immediate trigger
- `cfg_word_count`  in  CNT_W  number of words after the trigger; 0 means run until `abort`
- `trig_s`  in  32  synchronized sample bus used for trigger compare
- `smp_out_valid`  in  1  sampler output word strobe
- `avalid`, `awe`  out  1  sampler bus request and write enable
- `aaddr`  out  6  sampler register address
- `adata`  out  32  sampler write data
- `bvalid`  in  1  sampler response valid, one cycle after `avalid`
- `bdata`  in  32  sampler read data
- `busy`  out  1  high in every state except IDLE and DONE
- `armed`  out  1  high in ARM
- `done`  out  1  one-cycle pulse on entry to DONE
- `aborted`  out  1  last capture ended by `abort`
- `overflow_seen`  out  1  status bits [7:6] of the final poll, ORed
- `words_captured`  out  CNT_W  count of `smp_out_valid` pulses since the enable write
- `state_o`  out  3  current state encoding

## Operation
- States: IDLE → CFG → ARM → RUN → STOP → DRAIN → DONE.
  - DONE behaves like IDLE for `start`.
- CFG issues four back-to-back single-cycle writes, in this order:
  - 0x00 with bit1 (clear) set and bit0 (enable) clear.
  - 0x04 = `cfg_period`.
  - 0x08 = `cfg_rise_mask`.
  - 0x0C = `cfg_fall_mask`.
- ARM waits for a registered match: `(trig_s & cfg_trig_mask) == (cfg_trig_value & cfg_trig_mask)`.
- On a match, the block writes 0x00 with bit0 = 1 and bits[10:8] = `cfg_log_channels`, clears `words_captured`, and enters RUN.
- RUN increments `words_captured` on each `smp_out_valid`; the counter saturates at all-ones.
- RUN → STOP when the count reaches `cfg_word_count` (nonzero target) or on `abort`.
- STOP writes 0x00 with all bits zero (disable), then enters DRAIN.
- DRAIN counting: words arriving after the target or during DRAIN are still counted.
- DRAIN read loop:
  - Issue a read of 0x00 and wait for `bvalid`.
  - If `bdata[5]` (pipeline busy) = 1, reissue the read on the next cycle.
  - Otherwise latch `overflow_seen` from `bdata[7] | bdata[6]` and enter DONE.
- `abort` handling:
  - In CFG or ARM it goes straight to STOP.
  - It is ignored in IDLE, STOP, DRAIN and DONE.
  - It sets `aborted` only when it causes the exit.
- A `start` while `busy` is ignored. `start` clears `aborted` and `overflow_seen`.
- `bvalid` following a write is ignored.

## Timing
- Reset values:
  - All outputs are 0, `state_o` = IDLE.
  - `aaddr` and `adata` are 0.
- Bus outputs are registered. `avalid` is high for exactly one cycle per access, and there is at most one outstanding read.
- The first CFG write appears the cycle after `start` is sampled; the four writes occupy four consecutive cycles.
- Trigger latency: the compare is registered, so the enable write is driven 2 cycles after the matching `trig_s`.
- The terminal-count check uses the incremented value, so STOP's write issues the cycle after the final counted word.
- Same-cycle `abort` and terminal count: treated as normal completion, `aborted` = 0.
- Reset mid-capture returns to IDLE immediately and leaves the sampler in whatever state was last written.

## Structure
- Package `sampler_ctrl_pkg`:
  - register address constants 0x00/0x04/0x08/0x0C;
  - control bit positions (enable 0, clear 1, log_channels 10:8);
  - status bit positions (busy 5, overflows 7:6);
  - state enum.
- Sub-module `sampler_trigger_match`: registered masked comparator producing `hit`.

## Test plan
- Mask 0, target 4: `start` → writes to 0x00/04/08/0C on cycles 1–4, enable write on cycle 6; four `smp_out_valid` → disable write; poll returns 0x000 → `done`, `words_captured` = 4.
- Mask 0xFF, value 0xA5: drive `trig_s` = 0x12, then 0xA5 → stay in ARM during 0x12; enable write 2 cycles after 0xA5.
- Target 0, `abort` in RUN after 7 words → STOP, DONE with `aborted` = 1 and `words_captured` = 7.
- DRAIN poll returns 0x020 twice, then 0x0C0 → three reads issued, `overflow_seen` = 1.
- `abort` in ARM and `start` while busy → ARM → STOP with no enable write; the extra `start` is ignored.
- Assert reset in RUN → all outputs return to their reset values and `state_o` = IDLE the same cycle.
